// File: rtl/password_candidate_gen.sv
// Purpose: enumerates every NUM_CHARS-char candidate over [a-zA-Z0-9] as a base-62 odometer, packed ASCII for the hash core.
// Latency: first candidate valid the cycle after start; one candidate per cycle while cand_ready stays high.
// Backpressure: cand_valid & !cand_ready holds cand_data stable and stalls the odometer; abort ends the run on the next edge.
module password_candidate_gen #(
    parameter int NUM_CHARS = 4,
    parameter int MSG_WIDTH = 128,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [MSG_WIDTH-1:0] cand_data,
    output logic [7:0]           cand_width,
    output logic                 cand_valid,
    input  logic                 cand_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CNT_WIDTH-1:0] cand_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [7:0]           CAND_BITS = 8'(8 * NUM_CHARS);
    localparam logic [5:0]           DIGIT_MAX = 6'd61;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    state_t                     state_q, state_d;
    logic [NUM_CHARS-1:0][5:0]  digit_q, digit_d;
    logic [NUM_CHARS-1:0][5:0]  digit_inc;
    logic [MSG_WIDTH-1:0]       data_q, data_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       aborted_q, aborted_d;
    logic                       all_max;
    logic                       carry;
    logic                       hs;

    // Digit value to ASCII: 0-25 -> 'a'.., 26-51 -> 'A'.., 52-61 -> '0'..
    function automatic logic [7:0] digit_to_ascii(input logic [5:0] d);
        if (d < 6'd26) begin
            return 8'h61 + {2'b00, d};
        end else if (d < 6'd52) begin
            return 8'h41 + ({2'b00, d} - 8'd26);
        end else begin
            return 8'h30 + ({2'b00, d} - 8'd52);
        end
    endfunction

    // Char i lands in byte i; everything above the candidate stays zero.
    function automatic logic [MSG_WIDTH-1:0] pack_digits(input logic [NUM_CHARS-1:0][5:0] d);
        logic [MSG_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            r[8*i +: 8] = digit_to_ascii(d[i]);
        end
        return r;
    endfunction

    // Odometer successor (digit 0 fastest) and last-candidate detect.
    always_comb begin
        digit_inc = digit_q;
        carry     = 1'b1;
        all_max   = 1'b1;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (digit_q[i] != DIGIT_MAX) begin
                all_max = 1'b0;
            end
            if (carry) begin
                if (digit_q[i] == DIGIT_MAX) begin
                    digit_inc[i] = 6'd0;
                end else begin
                    digit_inc[i] = digit_q[i] + 6'd1;
                    carry        = 1'b0;
                end
            end
        end
    end

    // Next-state and datapath control; cand_ready only matters in RUN.
    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
        hs        = (state_q == ST_RUN) && cand_ready;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    digit_d   = '0;
                    data_d    = pack_digits('0);
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (hs && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                if (abort) begin
                    // A coincident handshake still counts, but nothing new is presented.
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (hs && all_max) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b0;
                end else if (hs) begin
                    digit_d = digit_inc;
                    data_d  = pack_digits(digit_inc);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            digit_q   <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end

    assign cand_data  = data_q;
    assign cand_width = CAND_BITS;
    assign cand_valid = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign aborted    = aborted_q;
    assign cand_count = cnt_q;

endmodule

// File: tb/tb_password_candidate_gen.sv
// Purpose: directed vector table plus hand-written sequences for carry, backpressure, reset and exhaustion.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: pseudo-random cand_ready with an index-based scoreboard.
module tb_password_candidate_gen;

    logic         clk;
    logic         reset;
    logic         start, abort, cand_ready;
    logic [127:0] cand_data;
    logic [7:0]   cand_width;
    logic         cand_valid, busy, done, aborted;
    logic [31:0]  cand_count;

    logic         start2, abort2, cand_ready2;
    logic [15:0]  cand_data2;
    logic [7:0]   cand_width2;
    logic         cand_valid2, busy2, done2, aborted2;
    logic [31:0]  cand_count2;

    int pass_cnt;
    int total_cnt;

    string ALPHA = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    password_candidate_gen #(.NUM_CHARS(4), .MSG_WIDTH(128), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cand_data(cand_data), .cand_width(cand_width), .cand_valid(cand_valid),
        .cand_ready(cand_ready), .busy(busy), .done(done), .aborted(aborted),
        .cand_count(cand_count)
    );

    password_candidate_gen #(.NUM_CHARS(2), .MSG_WIDTH(16), .CNT_WIDTH(32)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2),
        .cand_data(cand_data2), .cand_width(cand_width2), .cand_valid(cand_valid2),
        .cand_ready(cand_ready2), .busy(busy2), .done(done2), .aborted(aborted2),
        .cand_count(cand_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic         abort;
        logic         rdy;
        logic [127:0] data;
        logic [31:0]  cnt;
        logic [3:0]   flags;   // {valid, busy, done, aborted}
    } vec_t;

    function automatic vec_t mk(logic s, logic a, logic r, logic [127:0] d, logic [31:0] c, logic [3:0] f);
        vec_t v;
        v.start = s; v.abort = a; v.rdy = r; v.data = d; v.cnt = c; v.flags = f;
        return v;
    endfunction

    // Expected 4-char candidate for enumeration index n (base-62, char 0 least significant).
    function automatic logic [127:0] model(int unsigned n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = ALPHA[n % 62];
            n = n / 62;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t         vecs[10];
    logic [127:0] prev_data;
    int unsigned  n_acc;
    int           acc2;
    logic [15:0]  last2;
    logic         hs;

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset = 1'b0;
        start = 0; abort = 0; cand_ready = 0;
        start2 = 0; abort2 = 0; cand_ready2 = 0;
        #12 reset = 1'b1;
        tick();

        // Reset / idle state
        chk("reset_data", cand_data, 128'h0);
        chk("reset_count", cand_count, 32'd0);
        chk("reset_flags", {valid_busy_done_ab()}, 4'b0000);
        chk("reset_width", cand_width, 8'd32);

        // Directed table: start, stall, ignored start, abort with handshake, restart
        vecs[0] = mk(1, 0, 0, 128'h61616161, 0, 4'b1100);
        vecs[1] = mk(0, 0, 0, 128'h61616161, 0, 4'b1100);
        vecs[2] = mk(0, 0, 1, 128'h61616162, 1, 4'b1100);
        vecs[3] = mk(1, 0, 1, 128'h61616163, 2, 4'b1100);
        vecs[4] = mk(0, 0, 0, 128'h61616163, 2, 4'b1100);
        vecs[5] = mk(0, 1, 1, 128'h61616163, 3, 4'b0011);
        vecs[6] = mk(0, 1, 1, 128'h61616163, 3, 4'b0011);
        vecs[7] = mk(1, 0, 0, 128'h61616161, 0, 4'b1100);
        vecs[8] = mk(0, 1, 0, 128'h61616161, 0, 4'b0011);
        vecs[9] = mk(1, 0, 0, 128'h61616161, 0, 4'b1100);
        for (int i = 0; i < 10; i++) begin
            start = vecs[i].start; abort = vecs[i].abort; cand_ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_data", i), cand_data, vecs[i].data);
            chk($sformatf("vec%0d_count", i), cand_count, vecs[i].cnt);
            chk($sformatf("vec%0d_flags", i), valid_busy_done_ab(), vecs[i].flags);
        end
        start = 0; abort = 0;

        // Carry / wrap through 'z'->'A', 'Z'->'0', '9'->'a'+carry
        cand_ready = 1;
        for (int i = 1; i <= 62; i++) begin
            tick();
            if (i == 26) chk("carry_A", cand_data, 128'h61616141);
            if (i == 51) chk("carry_Z", cand_data[7:0], 8'h5A);
            if (i == 52) chk("carry_0", cand_data[7:0], 8'h30);
            if (i == 61) chk("carry_9", cand_data[7:0], 8'h39);
        end
        chk("carry_wrap", cand_data, 128'h61616261);
        chk("carry_count", cand_count, 32'd62);

        // Backpressure scoreboard from a fresh start
        cand_ready = 0; abort = 1;
        tick();
        abort = 0; start = 1;
        tick();
        start = 0;
        n_acc = 0;
        for (int i = 0; i < 500; i++) begin
            cand_ready = 1'($urandom_range(0, 1));
            prev_data  = cand_data;
            hs         = cand_valid && cand_ready;
            tick();
            if (hs) n_acc++;
            chk($sformatf("bp_data%0d", i), cand_data, model(n_acc));
            if (!hs) chk($sformatf("bp_hold%0d", i), cand_data, prev_data);
        end
        chk("bp_count", cand_count, 32'(n_acc));

        // Asynchronous reset mid-RUN, then idle with start low
        cand_ready = 1;
        #2 reset = 1'b0;
        #1;
        chk("async_data", cand_data, 128'h0);
        chk("async_count", cand_count, 32'd0);
        chk("async_flags", valid_busy_done_ab(), 4'b0000);
        cand_ready = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle%0d_vb", i), {cand_valid, busy}, 2'b00);
        end
        chk("idle_width", cand_width, 8'd32);

        // Exhaustion on the 2-char instance
        chk("exh_width", cand_width2, 8'd16);
        start2 = 1;
        tick();
        start2 = 0; cand_ready2 = 1;
        acc2 = 0; last2 = '0;
        for (int i = 0; i < 4000; i++) begin
            if (cand_valid2 && cand_ready2) begin
                acc2++;
                last2 = cand_data2;
            end
            tick();
            if (done2) break;
        end
        chk("exh_done", done2, 1'b1);
        chk("exh_accepts", 32'(acc2), 32'd3844);
        chk("exh_last", last2, 16'h3939);
        chk("exh_data", cand_data2, 16'h3939);
        chk("exh_count", cand_count2, 32'd3844);
        chk("exh_flags", {cand_valid2, busy2, aborted2}, 3'b000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    function automatic logic [3:0] valid_busy_done_ab();
        return {cand_valid, busy, done, aborted};
    endfunction

endmodule

// File: doc/password_candidate_gen.md
Name: password_candidate_gen

Overview:
- Upstream stage of the brute-force password search: enumerates every NUM_CHARS-character candidate over a 62-symbol alphabet and presents each, packed, to the MD5 hash core input with a valid/ready handshake.
- Replaces ad-hoc per-character counters in the supervisor with a single odometer engine.
- The supervisor drives start and abort (abort on hash match); the hash core consumes cand_data/cand_width.

Parameters:
- NUM_CHARS, 4, candidate length in characters (1..16).
- MSG_WIDTH, 128, width of packed message bus; must be >= 8*NUM_CHARS.
- CNT_WIDTH, 32, width of accepted-candidate counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins enumeration from the first candidate.
- abort  in  1  stop enumeration (password found); sampled each cycle in RUN.
- cand_data  out  MSG_WIDTH  packed candidate; char i at bits [8i+7:8i], bits above 8*NUM_CHARS zero.
- cand_width  out  8  constant 8*NUM_CHARS (32 for default).
- cand_valid  out  1  cand_data holds an unconsumed candidate.
- cand_ready  in  1  hash core accepts candidate this cycle.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- aborted  out  1  in DONE: 1 = ended by abort, 0 = space exhausted.
- cand_count  out  CNT_WIDTH  number of accepted handshakes since last start.

Behaviour:
- Alphabet, digit value 0..61: 'a'..'z' (0-25), 'A'..'Z' (26-51), '0'..'9' (52-61). Each char stored as a 6-bit digit; ASCII decoded combinationally into registered cand_data.
- Odometer: char 0 varies fastest. On accept, digit 0 increments; digit value 61 wraps to 0 and carries into the next digit. Transitions per position: 'z'->'A', 'Z'->'0', '9'->'a' plus carry.
- Last candidate: all digits 61 (all '9'). Total candidates = 62^NUM_CHARS (14,776,336 for 4).
- Reset (async assert, any state): state=IDLE, all digits 0, cand_data=0, cand_valid=0, busy=0, done=0, aborted=0, cand_count=0. cand_width is constant.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> RUN; next cycle cand_valid=1, cand_data=all 'a', cand_count=0.
- RUN: cand_valid=1.
  - Handshake (cand_valid & cand_ready): cand_count+1, and the next candidate is registered on the same edge. Throughput is one candidate per cycle when cand_ready is held high.
  - cand_valid & !cand_ready: cand_data held stable, no advance.
  - Handshake on the last candidate: -> DONE, aborted=0, cand_valid=0.
  - abort=1: -> DONE, aborted=1, cand_valid=0 next cycle. If a handshake occurs in the same cycle, it still counts (cand_count+1) but no new candidate is presented.
  - start during RUN is ignored.
- DONE: done=1; cand_data, cand_count and aborted hold. start=1 -> RUN, restarts from all 'a', clears cand_count and aborted. abort in DONE is ignored.
- IDLE/DONE: cand_valid=0, and cand_ready is ignored.
- cand_count saturates at all-ones; it never wraps.

Test Plan:
- Reset/idle: assert reset low mid-RUN -> all outputs 0 immediately (async). Release reset with start=0 for 5 cycles -> cand_valid=0, busy=0, cand_width=8'd32.
- First candidates: start pulse, cand_ready=1 -> cycle+1 cand_data=128'h61616161; next 128'h61616162; after 26 accepts 128'h61616141 ('A').
- Carry/wrap: cand_ready=1 for 62 accepts -> cand_data=128'h61616261 and cand_count=62. Confirm the sequence passes 0x5A ('Z') -> 0x30 ('0') -> 0x39 ('9') -> wrap.
- Backpressure: cand_ready toggled pseudo-randomly for 500 cycles -> cand_data stable while !cand_ready, no candidate skipped or duplicated (scoreboard), cand_count equals number of handshakes.
- Exhaustion (NUM_CHARS=2): cand_ready=1 -> 3844 accepts, last cand_data=16'h3939; then done=1, aborted=0, cand_count=3844, cand_valid=0.
- Abort: abort pulse coincident with accept of candidate 'aaac' (cand_count 2->3) -> DONE, aborted=1, cand_count=3, cand_data held at 128'h61616163; a following start pulse restarts at 128'h61616161 with cand_count=0.
